// File: rtl/adder_share_arbiter.sv
// Purpose : round-robin share of one external W-bit adder among NREQ requesters.
// Latency : handshake in cycle t -> rsp_valid in cycle t+ADD_LAT+1; one issue per ADD_LAT+2 cycles.
// Backpressure: rsp_ready low holds the response; no new grants until it is consumed.
module adder_share_arbiter #(
  parameter int W       = 12,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [2*W-1:0]    adder_in,
  input  logic [W:0]        adder_out,
  output logic              rsp_valid,
  output logic [W:0]        rsp_sum,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [3:0]     wait_cnt;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] rr_ptr_next;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic [2*W-1:0] adder_in_d;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping at NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!grant_found && req_valid[j]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(j);
      end
    end
  end

  // Grant is only offered from IDLE; one-hot by construction of the search above.
  always_comb begin
    req_ready = '0;
    if (!rst && state == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  // Select the granted operands and interleave them bitwise for the adder (A even, B odd).
  always_comb begin
    sel_a      = req_a[grant_idx*W +: W];
    sel_b      = req_b[grant_idx*W +: W];
    adder_in_d = '0;
    for (int i = 0; i < W; i++) begin
      adder_in_d[2*i]   = sel_a[i];
      adder_in_d[2*i+1] = sel_b[i];
    end
    rr_ptr_next = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
  end

  // Control FSM with registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      wait_cnt  <= '0;
      adder_in  <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            adder_in <= adder_in_d;
            rsp_id   <= grant_idx;
            rr_ptr   <= rr_ptr_next;
            wait_cnt <= 4'(ADD_LAT - 1);
            busy     <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // adder_in stays put while the external adder settles.
          if (wait_cnt == 4'd0) begin
            rsp_sum   <= adder_out;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;
  localparam int W    = 12;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT with ADD_LAT=1
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic [2*W-1:0]    adder_in;
  logic [W:0]        adder_out;
  logic              rsp_valid, rsp_ready, busy;
  logic [W:0]        rsp_sum;
  logic [IDW-1:0]    rsp_id;

  // DUT with ADD_LAT=3
  logic [NREQ-1:0]   l3_req_valid;
  logic [NREQ*W-1:0] l3_req_a, l3_req_b;
  logic [NREQ-1:0]   l3_req_ready;
  logic [2*W-1:0]    l3_adder_in;
  logic [W:0]        l3_adder_out;
  logic              l3_rsp_valid, l3_rsp_ready, l3_busy;
  logic [W:0]        l3_rsp_sum;
  logic [IDW-1:0]    l3_rsp_id;

  int tests = 0;
  int fails = 0;

  adder_share_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW), .ADD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .adder_in(adder_in), .adder_out(adder_out),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy));

  adder_share_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW), .ADD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(l3_req_valid), .req_a(l3_req_a), .req_b(l3_req_b),
    .req_ready(l3_req_ready), .adder_in(l3_adder_in), .adder_out(l3_adder_out),
    .rsp_valid(l3_rsp_valid), .rsp_sum(l3_rsp_sum), .rsp_id(l3_rsp_id),
    .rsp_ready(l3_rsp_ready), .busy(l3_busy));

  // Operand interleaving rule: bit 2i = A[i], bit 2i+1 = B[i].
  function automatic logic [2*W-1:0] ilv(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[2*i]   = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction

  // Behavioural model of the external shared adder.
  function automatic logic [W:0] ext_add(input logic [2*W-1:0] x);
    logic [W-1:0] a, b;
    for (int i = 0; i < W; i++) begin
      a[i] = x[2*i];
      b[i] = x[2*i+1];
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign adder_out    = ext_add(adder_in);
  assign l3_adder_out = ext_add(l3_adder_in);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int k);
    logic [NREQ-1:0] r;
    r    = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  typedef struct {
    int           k;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   sum;
    logic [2*W-1:0] ain;
  } vec_t;
  vec_t vecs[6];

  // One isolated transaction on the ADD_LAT=1 instance, checked cycle by cycle.
  task automatic run_single(input vec_t v);
    @(negedge clk);
    req_valid = onehot(v.k);
    req_a[v.k*W +: W] = v.a;
    req_b[v.k*W +: W] = v.b;
    rsp_ready = 1'b1;
    #1;
    check("single_ready", 32'(req_ready), 32'(onehot(v.k)));
    @(negedge clk);
    req_valid = '0;
    #1;
    check("single_busy_c1", 32'(busy), 32'd1);
    check("single_vld_c1", 32'(rsp_valid), 32'd0);
    check("single_adder_in", 32'(adder_in), 32'(v.ain));
    @(negedge clk); #1;
    check("single_vld_c2", 32'(rsp_valid), 32'd1);
    check("single_sum", 32'(rsp_sum), 32'(v.sum));
    check("single_id", 32'(rsp_id), v.k);
    @(negedge clk); #1;
    check("single_idle", 32'(busy), 32'd0);
    check("single_vld_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int g, r;
    int order[5];
    logic [W:0] es;
    // soak model state
    int m_ptr, m_id, m_gc, cyc, nresp, sg;
    bit m_busy, found, exp_vld;
    logic [W-1:0] m_a, m_b;
    logic [NREQ-1:0] exp_rdy, hs_mask;

    vecs[0] = '{2, 12'hFFF, 12'h001, 13'h1000, 24'h555557};
    vecs[1] = '{0, 12'h000, 12'h000, 13'h0000, 24'h000000};
    vecs[2] = '{3, 12'hFFF, 12'hFFF, 13'h1FFE, 24'hFFFFFF};
    vecs[3] = '{1, 12'h000, 12'hFFF, 13'h0FFF, 24'hAAAAAA};
    vecs[4] = '{2, 12'h800, 12'h800, 13'h1000, 24'hC00000};
    vecs[5] = '{0, 12'h001, 12'h000, 13'h0001, 24'h000001};

    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    l3_req_valid = '0; l3_req_a = '0; l3_req_b = '0; l3_rsp_ready = 1'b0;

    // Reset state, with requests asserted to confirm no grant during reset.
    @(negedge clk);
    req_valid = '1; l3_req_valid = '1;
    @(negedge clk); #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_vld", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_adder_in", 32'(adder_in), 32'd0);
    check("rst_sum", 32'(rsp_sum), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_l3_ready", 32'(l3_req_ready), 32'd0);
    check("rst_l3_busy", 32'(l3_busy), 32'd0);
    req_valid = '0; l3_req_valid = '0;
    rst = 1'b0;

    // Table-driven single transactions.
    for (int i = 0; i < 6; i++) run_single(vecs[i]);

    // Round robin with all four requesters held valid.
    do_reset();
    order = '{0, 1, 2, 3, 0};
    g = 0; r = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          req_a[k*W +: W] = 12'(12'h111 * (k + 1));
          req_b[k*W +: W] = 12'(12'h0F0 + k);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
      end
      #1;
      if (req_ready != '0 && g < 5) begin
        check("rr_grant", 32'(req_ready), 32'(onehot(order[g])));
        check("rr_spacing", c, 3 * g);
        g++;
      end
      if (rsp_valid && r < 5) begin
        es = 13'(req_a[order[r]*W +: W]) + 13'(req_b[order[r]*W +: W]);
        check("rr_id", 32'(rsp_id), order[r]);
        check("rr_sum", 32'(rsp_sum), 32'(es));
        r++;
      end
    end
    req_valid = '0;
    check("rr_grants", g, 5);
    check("rr_rsps", r, 5);

    // Backpressure: response held 5 cycles with other requesters waiting.
    @(negedge clk);
    req_valid = onehot(1);
    req_a[1*W +: W] = 12'h0AB;
    req_b[1*W +: W] = 12'h0CD;
    rsp_ready = 1'b0;
    #1;
    check("bp_grant", 32'(req_ready), 32'(onehot(1)));
    @(negedge clk);
    req_valid = 4'b0101;
    #1;
    check("bp_noready_wait", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("bp_vld", 32'(rsp_valid), 32'd1);
      check("bp_sum", 32'(rsp_sum), 32'h178);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_noready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_vld_last", 32'(rsp_valid), 32'd1);
    @(negedge clk); #1;
    check("bp_idle", 32'(busy), 32'd0);
    check("bp_vld_drop", 32'(rsp_valid), 32'd0);
    check("bp_next_grant", 32'(req_ready), 32'(onehot(2)));
    req_valid = '0;

    // ADD_LAT=3 latency and operand stability.
    @(negedge clk);
    l3_req_valid = onehot(0);
    l3_req_a[0 +: W] = 12'h123;
    l3_req_b[0 +: W] = 12'h456;
    l3_rsp_ready = 1'b1;
    #1;
    check("l3_grant", 32'(l3_req_ready), 32'(onehot(0)));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      l3_req_valid = '0;
      #1;
      check("l3_adder_in_stable", 32'(l3_adder_in), 32'(ilv(12'h123, 12'h456)));
      check("l3_vld_early", 32'(l3_rsp_valid), 32'd0);
      check("l3_busy", 32'(l3_busy), 32'd1);
    end
    @(negedge clk); #1;
    check("l3_vld", 32'(l3_rsp_valid), 32'd1);
    check("l3_sum", 32'(l3_rsp_sum), 32'h579);
    check("l3_id", 32'(l3_rsp_id), 32'd0);
    @(negedge clk); #1;
    check("l3_idle", 32'(l3_busy), 32'd0);

    // Reset in the second WAIT cycle discards the operation and rr_ptr.
    @(negedge clk);
    l3_req_valid = onehot(2);
    l3_req_a[2*W +: W] = 12'h3AA;
    l3_req_b[2*W +: W] = 12'h155;
    #1;
    check("mr_grant", 32'(l3_req_ready), 32'(onehot(2)));
    @(negedge clk);
    l3_req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_vld", 32'(l3_rsp_valid), 32'd0);
    check("mr_busy", 32'(l3_busy), 32'd0);
    check("mr_adder_in", 32'(l3_adder_in), 32'd0);
    check("mr_sum", 32'(l3_rsp_sum), 32'd0);
    check("mr_id", 32'(l3_rsp_id), 32'd0);
    check("mr_ready", 32'(l3_req_ready), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      check("mr_no_rsp", 32'(l3_rsp_valid), 32'd0);
    end
    @(negedge clk);
    l3_req_valid = 4'b1010;
    l3_req_a[1*W +: W] = 12'h00F;
    l3_req_b[1*W +: W] = 12'h0F1;
    #1;
    check("mr_rrptr_zero", 32'(l3_req_ready), 32'(onehot(1)));
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      l3_req_valid = '0;
      #1;
      check("mr2_vld_early", 32'(l3_rsp_valid), 32'd0);
    end
    @(negedge clk); #1;
    check("mr2_vld", 32'(l3_rsp_valid), 32'd1);
    check("mr2_sum", 32'(l3_rsp_sum), 32'h100);
    check("mr2_id", 32'(l3_rsp_id), 32'd1);

    // Random soak against a transaction-level model of the arbiter.
    do_reset();
    m_ptr = 0; m_busy = 1'b0; m_id = 0; m_gc = 0; m_a = '0; m_b = '0;
    cyc = 0; nresp = 0; hs_mask = '0;
    while (nresp < 10000 && cyc < 60000) begin
      @(negedge clk);
      req_valid = req_valid & ~hs_mask;
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid[k]) begin
          if ($urandom_range(0, 15) == 0) req_valid[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_valid[k] = 1'b1;
          req_a[k*W +: W] = 12'($urandom);
          req_b[k*W +: W] = 12'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 7) != 0);
      #1;
      found = 1'b0; sg = 0;
      if (!m_busy) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req_valid[(m_ptr + i) % NREQ]) begin
            found = 1'b1;
            sg = (m_ptr + i) % NREQ;
          end
        end
      end
      exp_rdy = found ? onehot(sg) : '0;
      exp_vld = m_busy && (cyc >= m_gc + 2);
      check("soak_ready", 32'(req_ready), 32'(exp_rdy));
      check("soak_vld", 32'(rsp_valid), 32'(exp_vld));
      if (rsp_valid && exp_vld) begin
        es = 13'(m_a) + 13'(m_b);
        check("soak_sum", 32'(rsp_sum), 32'(es));
        check("soak_id", 32'(rsp_id), m_id);
      end
      hs_mask = req_ready & req_valid;
      if (found) begin
        m_busy = 1'b1;
        m_id   = sg;
        m_a    = req_a[sg*W +: W];
        m_b    = req_b[sg*W +: W];
        m_gc   = cyc;
        m_ptr  = (sg + 1) % NREQ;
      end else if (exp_vld && rsp_ready) begin
        m_busy = 1'b0;
        nresp++;
      end
      cyc++;
    end
    req_valid = '0;
    check("soak_completed", nresp, 10000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
